// File: rtl/note_env_ctrl.sv
// Per-voice note sequencer and ADSR envelope controller for one triangle source.
// Accepts note-on/off over valid/ready and steps the source volume on a divided envelope tick.
module note_env_ctrl #(
    parameter int unsigned VOLUME_BITS   = 4,
    parameter int unsigned FREQ_RES_BITS = 16,
    parameter int unsigned TICK_DIV      = 4096,
    parameter int unsigned RATE_BITS     = 8
) (
    input  logic                     mclk,
    input  logic                     rst,
    input  logic                     note_valid,
    output logic                     note_ready,
    input  logic                     note_on,
    input  logic [FREQ_RES_BITS-1:0] note_freq,
    input  logic [VOLUME_BITS-1:0]   note_vel,
    input  logic [RATE_BITS-1:0]     attack_rate,
    input  logic [RATE_BITS-1:0]     decay_rate,
    input  logic [RATE_BITS-1:0]     release_rate,
    input  logic [VOLUME_BITS-1:0]   sustain_level,
    output logic [FREQ_RES_BITS-1:0] p_frequency,
    output logic [VOLUME_BITS-1:0]   volume,
    output logic [2:0]               env_state,
    output logic                     active
);

    localparam int unsigned PRE_BITS  = $clog2(TICK_DIV);
    localparam int unsigned VEXT_BITS = VOLUME_BITS + 1;
    localparam logic [PRE_BITS-1:0] PRE_LAST = PRE_BITS'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_e;

    logic [PRE_BITS-1:0]      pre_q, pre_d;
    logic                     ready_q, ready_d;
    env_state_e               state_q, state_d;
    logic [RATE_BITS-1:0]     step_q, step_d;
    logic [VOLUME_BITS-1:0]   vol_q, vol_d;
    logic [VOLUME_BITS-1:0]   peak_q, peak_d;
    logic [FREQ_RES_BITS-1:0] freq_q, freq_d;
    logic                     active_q;

    logic                     accept;
    logic                     env_tick;
    logic                     step_hit;
    logic                     in_note;
    logic [RATE_BITS-1:0]     rate_cur;
    logic [VOLUME_BITS-1:0]   sus_eff;
    logic [VEXT_BITS-1:0]     vol_inc;

    assign accept   = note_valid && ready_q;
    assign env_tick = (pre_q == PRE_LAST);
    assign sus_eff  = (sustain_level < peak_q) ? sustain_level : peak_q;
    assign vol_inc  = VEXT_BITS'(vol_q) + VEXT_BITS'(1);
    assign in_note  = (state_q == ST_ATTACK) || (state_q == ST_DECAY) ||
                      (state_q == ST_SUSTAIN);

    // Rate governing the step counter in the current phase
    always_comb begin
        rate_cur = '0;
        case (state_q)
            ST_ATTACK:  rate_cur = attack_rate;
            ST_DECAY:   rate_cur = decay_rate;
            ST_RELEASE: rate_cur = release_rate;
            default:    rate_cur = '0;
        endcase
    end

    assign step_hit = env_tick && (step_q == rate_cur);

    // Next-state: a command always overrides an envelope step in the same cycle
    always_comb begin
        pre_d   = env_tick ? '0 : pre_q + PRE_BITS'(1);
        ready_d = !accept;
        state_d = state_q;
        step_d  = step_q;
        vol_d   = vol_q;
        peak_d  = peak_q;
        freq_d  = freq_q;

        if (accept) begin
            step_d = '0;
            if (note_on) begin
                freq_d  = note_freq;
                peak_d  = note_vel;
                state_d = ST_ATTACK;
            end else if (in_note) begin
                state_d = ST_RELEASE;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    vol_d  = '0;
                    step_d = '0;
                end
                ST_ATTACK, ST_DECAY, ST_RELEASE: begin
                    if (env_tick) begin
                        step_d = step_hit ? '0 : step_q + RATE_BITS'(1);
                    end
                    if (step_hit) begin
                        if (state_q == ST_ATTACK) begin
                            if ((peak_q == '0) || (vol_inc >= VEXT_BITS'(peak_q))) begin
                                vol_d   = peak_q;
                                state_d = ST_DECAY;
                            end else begin
                                vol_d = vol_q + VOLUME_BITS'(1);
                            end
                        end else if (state_q == ST_DECAY) begin
                            if (vol_q <= sus_eff) begin
                                state_d = ST_SUSTAIN;
                            end else begin
                                vol_d = vol_q - VOLUME_BITS'(1);
                            end
                        end else begin
                            if (vol_q <= VOLUME_BITS'(1)) begin
                                vol_d   = '0;
                                state_d = ST_IDLE;
                            end else begin
                                vol_d = vol_q - VOLUME_BITS'(1);
                            end
                        end
                    end
                end
                ST_SUSTAIN: begin
                    step_d = '0;
                    if (env_tick) begin
                        if (vol_q < sus_eff) begin
                            vol_d = vol_q + VOLUME_BITS'(1);
                        end else if (vol_q > sus_eff) begin
                            vol_d = vol_q - VOLUME_BITS'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    vol_d   = '0;
                    step_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            pre_q    <= '0;
            ready_q  <= 1'b0;
            state_q  <= ST_IDLE;
            step_q   <= '0;
            vol_q    <= '0;
            peak_q   <= '0;
            freq_q   <= '0;
            active_q <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            ready_q  <= ready_d;
            state_q  <= state_d;
            step_q   <= step_d;
            vol_q    <= vol_d;
            peak_q   <= peak_d;
            freq_q   <= freq_d;
            active_q <= (state_d != ST_IDLE);
        end
    end

    assign note_ready  = ready_q;
    assign p_frequency = freq_q;
    assign volume      = vol_q;
    assign env_state   = state_q;
    assign active      = active_q;

endmodule

// File: tb/tb_note_env_ctrl.sv
// Directed bench for note_env_ctrl with a 4-cycle envelope tick.
// Each task drives one scenario and checks hand-computed envelope values.
module tb_note_env_ctrl;

    logic        mclk = 1'b0;
    logic        rst;
    logic        note_valid;
    logic        note_ready;
    logic        note_on;
    logic [15:0] note_freq;
    logic [3:0]  note_vel;
    logic [7:0]  attack_rate;
    logic [7:0]  decay_rate;
    logic [7:0]  release_rate;
    logic [3:0]  sustain_level;
    logic [15:0] p_frequency;
    logic [3:0]  volume;
    logic [2:0]  env_state;
    logic        active;

    int total = 0;
    int bad   = 0;

    note_env_ctrl #(
        .VOLUME_BITS  (4),
        .FREQ_RES_BITS(16),
        .TICK_DIV     (4),
        .RATE_BITS    (8)
    ) dut (
        .mclk         (mclk),
        .rst          (rst),
        .note_valid   (note_valid),
        .note_ready   (note_ready),
        .note_on      (note_on),
        .note_freq    (note_freq),
        .note_vel     (note_vel),
        .attack_rate  (attack_rate),
        .decay_rate   (decay_rate),
        .release_rate (release_rate),
        .sustain_level(sustain_level),
        .p_frequency  (p_frequency),
        .volume       (volume),
        .env_state    (env_state),
        .active       (active)
    );

    always #5 mclk = ~mclk;

    // Issue one command once ready is seen; returns at the negedge after acceptance
    task automatic send(input logic on, input logic [15:0] f, input logic [3:0] v);
        int n = 0;
        while (note_ready !== 1'b1 && n < 8) begin
            @(negedge mclk);
            n++;
        end
        if (n >= 8) begin
            total++; bad++;
            $display("FAIL send_ready_timeout: note_ready=%b required 1", note_ready);
        end
        note_valid = 1'b1;
        note_on    = on;
        note_freq  = f;
        note_vel   = v;
        @(negedge mclk);
        note_valid = 1'b0;
    endtask

    // Wait for volume to leave prev; dt = negedges elapsed
    task automatic wait_change(input logic [3:0] prev, output logic [3:0] v, output int dt);
        dt = 0;
        while (volume === prev && dt < 80) begin
            @(negedge mclk);
            dt++;
        end
        v = volume;
        if (dt >= 80) begin
            total++; bad++;
            $display("FAIL volume_change_timeout: volume=%0d stuck", volume);
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        repeat (3) @(negedge mclk);
        total++;
        if ({p_frequency, volume, env_state, active, note_ready} !== 25'd0) begin
            bad++;
            $display("FAIL reset_values: freq=%h vol=%0d st=%0d act=%b rdy=%b required all 0",
                     p_frequency, volume, env_state, active, note_ready);
        end
        rst = 1'b0;
        total++;
        if (note_ready !== 1'b0) begin
            bad++; $display("FAIL ready_before_edge: got %b required 0", note_ready);
        end
        @(negedge mclk);
        total++;
        if (note_ready !== 1'b1) begin
            bad++; $display("FAIL ready_after_deassert: got %b required 1", note_ready);
        end
        // Reset in the middle of an attack
        attack_rate = 8'd0;
        send(1'b1, 16'hABCD, 4'd15);
        n = 0;
        while (volume !== 4'd5 && n < 80) begin
            @(negedge mclk);
            n++;
        end
        total++;
        if (volume !== 4'd5 || env_state !== 3'd1) begin
            bad++; $display("FAIL reach_attack_5: vol=%0d st=%0d required 5/1", volume, env_state);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (volume !== 4'd0 || env_state !== 3'd0 || note_ready !== 1'b0 ||
            active !== 1'b0 || p_frequency !== 16'h0) begin
            bad++;
            $display("FAIL async_reset: vol=%0d st=%0d rdy=%b act=%b freq=%h required 0",
                     volume, env_state, note_ready, active, p_frequency);
        end
        @(negedge mclk);
        rst = 1'b0;
        @(negedge mclk);
        total++;
        if (note_ready !== 1'b1) begin
            bad++; $display("FAIL ready_after_mid_reset: got %b required 1", note_ready);
        end
    endtask

    task automatic test_stray_note_off();
        send(1'b0, 16'h5555, 4'd7);
        total++;
        if (env_state !== 3'd0 || volume !== 4'd0 || note_ready !== 1'b0 || active !== 1'b0) begin
            bad++;
            $display("FAIL stray_off: st=%0d vol=%0d rdy=%b act=%b required 0/0/0/0",
                     env_state, volume, note_ready, active);
        end
        @(negedge mclk);
        total++;
        if (note_ready !== 1'b1 || env_state !== 3'd0 || p_frequency !== 16'h0) begin
            bad++;
            $display("FAIL stray_off_after: rdy=%b st=%0d freq=%h required 1/0/0000",
                     note_ready, env_state, p_frequency);
        end
    endtask

    task automatic test_full_adsr();
        logic [3:0] prev, v;
        int dt;
        attack_rate = 8'd0; decay_rate = 8'd1; sustain_level = 4'd3; release_rate = 8'd0;
        send(1'b1, 16'h1234, 4'd8);
        total++;
        if (p_frequency !== 16'h1234 || env_state !== 3'd1 || note_ready !== 1'b0 ||
            active !== 1'b1) begin
            bad++;
            $display("FAIL adsr_accept: freq=%h st=%0d rdy=%b act=%b required 1234/1/0/1",
                     p_frequency, env_state, note_ready, active);
        end
        prev = 4'd0;
        for (int i = 1; i <= 8; i++) begin
            wait_change(prev, v, dt);
            total++;
            if (v !== 4'(i) || (i > 1 && dt != 4)) begin
                bad++; $display("FAIL attack_step%0d: vol=%0d dt=%0d required %0d/4", i, v, dt, i);
            end
            prev = v;
        end
        total++;
        if (env_state !== 3'd2) begin
            bad++; $display("FAIL attack_to_decay: st=%0d required 2", env_state);
        end
        for (int i = 7; i >= 3; i--) begin
            wait_change(prev, v, dt);
            total++;
            if (v !== 4'(i) || dt != 8) begin
                bad++; $display("FAIL decay_step%0d: vol=%0d dt=%0d required %0d/8", i, v, dt, i);
            end
            prev = v;
        end
        repeat (20) @(negedge mclk);
        total++;
        if (env_state !== 3'd3 || volume !== 4'd3) begin
            bad++; $display("FAIL sustain_hold: st=%0d vol=%0d required 3/3", env_state, volume);
        end
        send(1'b0, 16'h0, 4'd0);
        total++;
        if (env_state !== 3'd4 || p_frequency !== 16'h1234) begin
            bad++; $display("FAIL release_enter: st=%0d freq=%h required 4/1234", env_state, p_frequency);
        end
        for (int i = 2; i >= 0; i--) begin
            wait_change(prev, v, dt);
            total++;
            if (v !== 4'(i) || (i < 2 && dt != 4)) begin
                bad++; $display("FAIL release_step%0d: vol=%0d dt=%0d required %0d/4", i, v, dt, i);
            end
            prev = v;
        end
        total++;
        if (env_state !== 3'd0 || active !== 1'b0 || p_frequency !== 16'h1234) begin
            bad++;
            $display("FAIL release_idle: st=%0d act=%b freq=%h required 0/0/1234",
                     env_state, active, p_frequency);
        end
    endtask

    task automatic test_sustain_above_peak();
        logic [3:0] prev, v;
        int dt;
        attack_rate = 8'd0; decay_rate = 8'd0; sustain_level = 4'd10; release_rate = 8'd3;
        @(negedge mclk);
        send(1'b1, 16'h0200, 4'd4);
        prev = 4'd0;
        for (int i = 1; i <= 4; i++) begin
            wait_change(prev, v, dt);
            total++;
            if (v !== 4'(i)) begin
                bad++; $display("FAIL sus_attack%0d: vol=%0d required %0d", i, v, i);
            end
            prev = v;
        end
        repeat (24) @(negedge mclk);
        total++;
        if (env_state !== 3'd3 || volume !== 4'd4) begin
            bad++; $display("FAIL sustain_capped: st=%0d vol=%0d required 3/4", env_state, volume);
        end
    endtask

    task automatic test_retrigger_release();
        logic [3:0] prev, v;
        int dt, n;
        send(1'b0, 16'h0, 4'd0);
        prev = 4'd4;
        wait_change(prev, v, dt);
        total++;
        if (v !== 4'd3 || env_state !== 3'd4) begin
            bad++; $display("FAIL slow_release3: vol=%0d st=%0d required 3/4", v, env_state);
        end
        prev = v;
        wait_change(prev, v, dt);
        total++;
        if (v !== 4'd2 || dt != 16) begin
            bad++; $display("FAIL slow_release2: vol=%0d dt=%0d required 2/16", v, dt);
        end
        prev = v;
        send(1'b1, 16'h0300, 4'd6);
        total++;
        if (volume !== 4'd2 || env_state !== 3'd1 || p_frequency !== 16'h0300) begin
            bad++;
            $display("FAIL retrigger_accept: vol=%0d st=%0d freq=%h required 2/1/0300",
                     volume, env_state, p_frequency);
        end
        for (int i = 3; i <= 6; i++) begin
            wait_change(prev, v, dt);
            total++;
            if (v !== 4'(i)) begin
                bad++; $display("FAIL retrigger_step%0d: vol=%0d required %0d", i, v, i);
            end
            prev = v;
        end
        total++;
        if (env_state !== 3'd2) begin
            bad++; $display("FAIL retrigger_decay: st=%0d required 2", env_state);
        end
        release_rate = 8'd0;
        repeat (8) @(negedge mclk);
        send(1'b0, 16'h0, 4'd0);
        n = 0;
        while (env_state !== 3'd0 && n < 80) begin
            @(negedge mclk);
            n++;
        end
        total++;
        if (env_state !== 3'd0 || volume !== 4'd0 || active !== 1'b0) begin
            bad++;
            $display("FAIL retrigger_idle: st=%0d vol=%0d act=%b required 0/0/0", env_state, volume, active);
        end
    endtask

    task automatic test_handshake();
        logic [15:0] freqs [4];
        logic        rdy_exp [4];
        logic        rdy_obs [4];
        int acc = 0;
        int n = 0;
        freqs[0] = 16'h1111; freqs[1] = 16'h2222; freqs[2] = 16'h3333; freqs[3] = 16'h4444;
        rdy_exp[0] = 1'b1; rdy_exp[1] = 1'b0; rdy_exp[2] = 1'b1; rdy_exp[3] = 1'b0;
        while (note_ready !== 1'b1 && n < 8) begin
            @(negedge mclk);
            n++;
        end
        note_valid = 1'b1;
        note_on    = 1'b1;
        note_vel   = 4'd3;
        for (int i = 0; i < 4; i++) begin
            note_freq  = freqs[i];
            rdy_obs[i] = note_ready;
            if (note_ready === 1'b1) acc++;
            @(negedge mclk);
        end
        note_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rdy_obs[i] !== rdy_exp[i]) begin
                bad++; $display("FAIL hs_ready%0d: got %b required %b", i, rdy_obs[i], rdy_exp[i]);
            end
        end
        total++;
        if (acc != 2) begin
            bad++; $display("FAIL hs_accept_count: got %0d required 2", acc);
        end
        total++;
        if (p_frequency !== 16'h3333 || env_state !== 3'd1) begin
            bad++; $display("FAIL hs_last_cmd: freq=%h st=%0d required 3333/1", p_frequency, env_state);
        end
    endtask

    initial begin
        rst = 1'b1;
        note_valid = 1'b0; note_on = 1'b0; note_freq = '0; note_vel = '0;
        attack_rate = '0; decay_rate = '0; release_rate = '0; sustain_level = '0;
        @(negedge mclk);
        test_reset();
        test_stray_note_off();
        test_full_adsr();
        test_sustain_above_peak();
        test_retrigger_release();
        test_handshake();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
